// File: rtl/xain_pkg.sv
// Shared types, constants and saturation/attenuation helpers for the
// Xain'd Sleena audio output stage.
package xain_pkg;

    typedef logic signed [15:0] audio_sample_t;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;

    localparam audio_sample_t AUDIO_SAT_MAX = 16'sh7FFF;
    localparam audio_sample_t AUDIO_SAT_MIN = 16'sh8000;

    // 17-bit sum; overflow shows up as the two top bits disagreeing.
    function automatic audio_sample_t sat_sum(input audio_sample_t a, input audio_sample_t b);
        logic signed [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return s[16] ? AUDIO_SAT_MIN : AUDIO_SAT_MAX;
        end else begin
            return s[15:0];
        end
    endfunction

    function automatic audio_sample_t attenuate(input audio_sample_t x, input logic [1:0] v);
        return x >>> v;
    endfunction

endpackage

// File: rtl/xain_i2s_tx.sv
// I2S serialiser: SCLK divider, 64-bit frame counter, MSB-first shift
// register and a one-cycle frame strobe when the words are latched.
module xain_i2s_tx
    import xain_pkg::*;
#(
    parameter int SCLK_HALF = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  audio_sample_t left,
    input  audio_sample_t right,
    output logic          i2s_sclk,
    output logic          i2s_lrck,
    output logic          i2s_dat,
    output logic          frame_strobe
);

    localparam int                BIT_W    = $clog2(I2S_FRAME_BITS);
    localparam int                DIV_W    = $clog2(SCLK_HALF);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCLK_HALF - 1);
    localparam logic [BIT_W-1:0]  RSLOT    = BIT_W'(I2S_SLOT_BITS);

    logic [DIV_W-1:0] div_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             sclk_r;
    logic             lrck_r;
    logic             dat_r;
    logic             strobe_r;
    logic [15:0]      shift_r;
    logic [15:0]      right_hold_r;

    logic             div_wrap_s;
    logic             shift_evt_s;
    logic [BIT_W-1:0] bit_next_s;
    logic             in_word_s;

    // Divider wrap, shift-event and slot decode for the upcoming bit.
    always_comb begin
        div_wrap_s  = (div_cnt_r == DIV_LAST);
        shift_evt_s = div_wrap_s && sclk_r;
        bit_next_s  = bit_cnt_r + BIT_W'(1);
        in_word_s   = (bit_next_s[4:0] >= 5'd1) && (bit_next_s[4:0] <= 5'd16);
    end

    // Divider, bit counter and serial data; data/LRCK move only on falling SCLK.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r    <= '0;
            bit_cnt_r    <= 6'd63;
            sclk_r       <= 1'b0;
            lrck_r       <= 1'b0;
            dat_r        <= 1'b0;
            strobe_r     <= 1'b0;
            shift_r      <= 16'h0000;
            right_hold_r <= 16'h0000;
        end else begin
            strobe_r <= 1'b0;
            if (div_wrap_s) begin
                div_cnt_r <= '0;
                sclk_r    <= ~sclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (shift_evt_s) begin
                bit_cnt_r <= bit_next_s;
                lrck_r    <= bit_next_s[5];
                if (bit_next_s == 6'd0) begin
                    strobe_r     <= 1'b1;
                    shift_r      <= left;
                    right_hold_r <= right;
                    dat_r        <= 1'b0;
                end else if (bit_next_s == RSLOT) begin
                    shift_r <= right_hold_r;
                    dat_r   <= 1'b0;
                end else if (in_word_s) begin
                    dat_r   <= shift_r[15];
                    shift_r <= {shift_r[14:0], 1'b0};
                end else begin
                    dat_r <= 1'b0;
                end
            end
        end
    end

    assign i2s_sclk     = sclk_r;
    assign i2s_lrck     = lrck_r;
    assign i2s_dat      = dat_r;
    assign frame_strobe = strobe_r;

endmodule

// File: rtl/xain_audio_i2s.sv
// Audio output stage: stereo/mono mix with saturation, volume, mute and I2S
// serialisation. Define XAIN_AUDIO_LPF_EN to add a per-frame one-pole low-pass.
module xain_audio_i2s
    import xain_pkg::*;
#(
    parameter int SCLK_HALF = 8,
    parameter int LPF_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] snd1,
    input  logic [15:0] snd2,
    input  logic        mix_mode,
    input  logic [1:0]  vol,
    input  logic        mute,
    output logic        i2s_sclk,
    output logic        i2s_lrck,
    output logic        i2s_dat,
    output logic        frame_strobe
);

    audio_sample_t mono_s;
    audio_sample_t pre_l_s;
    audio_sample_t pre_r_s;
    audio_sample_t next_l_s;
    audio_sample_t next_r_s;
    audio_sample_t mix_l_r;
    audio_sample_t mix_r_r;
    audio_sample_t tx_l_s;
    audio_sample_t tx_r_s;
    logic          strobe_s;

    // Mix selection, volume shift and mute ahead of the mix register.
    always_comb begin
        mono_s = sat_sum(snd1, snd2);
        if (mix_mode) begin
            pre_l_s = mono_s;
            pre_r_s = mono_s;
        end else begin
            pre_l_s = snd1;
            pre_r_s = snd2;
        end
        if (mute) begin
            next_l_s = 16'sh0000;
            next_r_s = 16'sh0000;
        end else begin
            next_l_s = attenuate(pre_l_s, vol);
            next_r_s = attenuate(pre_r_s, vol);
        end
    end

    // Mix register: refreshed every clock, sampled by the serialiser at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_l_r <= 16'sh0000;
            mix_r_r <= 16'sh0000;
        end else begin
            mix_l_r <= next_l_s;
            mix_r_r <= next_r_s;
        end
    end

`ifdef XAIN_AUDIO_LPF_EN
    audio_sample_t lpf_l_r;
    audio_sample_t lpf_r_r;

    function automatic audio_sample_t lpf_step(input audio_sample_t y, input audio_sample_t x);
        logic signed [16:0] d;
        logic signed [16:0] step;
        d    = {x[15], x} - {y[15], y};
        step = d >>> LPF_SHIFT;
        return y + step[15:0];
    endfunction

    // Filter state advances once per frame; the serialiser sends y a frame later.
    always_ff @(posedge clk) begin
        if (reset) begin
            lpf_l_r <= 16'sh0000;
            lpf_r_r <= 16'sh0000;
        end else if (strobe_s) begin
            lpf_l_r <= lpf_step(lpf_l_r, mix_l_r);
            lpf_r_r <= lpf_step(lpf_r_r, mix_r_r);
        end
    end

    assign tx_l_s = lpf_l_r;
    assign tx_r_s = lpf_r_r;
`else
    assign tx_l_s = mix_l_r;
    assign tx_r_s = mix_r_r;
`endif

    xain_i2s_tx #(
        .SCLK_HALF (SCLK_HALF)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .left         (tx_l_s),
        .right        (tx_r_s),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_dat      (i2s_dat),
        .frame_strobe (strobe_s)
    );

    assign frame_strobe = strobe_s;

endmodule

// File: tb/tb_xain_audio_i2s.sv
// Directed bench for xain_audio_i2s with SCLK_HALF=2 (default build, no LPF).
module tb_xain_audio_i2s;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] snd1 = 16'h0000;
    logic [15:0] snd2 = 16'h0000;
    logic        mix_mode = 1'b0;
    logic [1:0]  vol = 2'd0;
    logic        mute = 1'b0;
    logic        i2s_sclk, i2s_lrck, i2s_dat, frame_strobe;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] WORD_MASK = 64'h0001_FFFE_0001_FFFE;
    localparam logic [63:0] LRCK_EXP  = 64'hFFFF_FFFF_0000_0000;

    xain_audio_i2s #(.SCLK_HALF(2), .LPF_SHIFT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .snd1         (snd1),
        .snd2         (snd2),
        .mix_mode     (mix_mode),
        .vol          (vol),
        .mute         (mute),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_dat      (i2s_dat),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a strobe, samples all 64 bits, optionally changes
    // vol/mute when bit chg_bit is reached, and returns the two words.
    task automatic capture(input string tag, input int chg_bit, input logic [1:0] cv,
                           input logic cm, output logic [15:0] lw, output logic [15:0] rw);
        logic [63:0] dat_v;
        logic [63:0] lr_v;
        int n;
        n = 0;
        while (!frame_strobe && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_strobe_seen"}, {63'd0, frame_strobe}, 64'd1);
        for (int k = 0; k < 64; k++) begin
            if (k == 1) begin
                @(negedge clk);
                chk({tag, "_strobe_width"}, {63'd0, frame_strobe}, 64'd0);
                repeat (3) @(negedge clk);
            end else if (k > 1) begin
                repeat (4) @(negedge clk);
            end
            dat_v[k] = i2s_dat;
            lr_v[k]  = i2s_lrck;
            if (k == chg_bit) begin
                vol  = cv;
                mute = cm;
            end
        end
        for (int i = 0; i < 16; i++) begin
            lw[15-i] = dat_v[1+i];
            rw[15-i] = dat_v[33+i];
        end
        chk({tag, "_pad_zero"}, dat_v & ~WORD_MASK, 64'd0);
        chk({tag, "_lrck"}, lr_v, LRCK_EXP);
    endtask

    logic [15:0] lw, rw;
    int cnt;

    initial begin
        // Reset state
        snd1 = 16'h8001;
        snd2 = 16'h7FFE;
        repeat (3) @(negedge clk);
        chk("rst_sclk", {63'd0, i2s_sclk}, 64'd0);
        chk("rst_lrck", {63'd0, i2s_lrck}, 64'd0);
        chk("rst_dat", {63'd0, i2s_dat}, 64'd0);
        chk("rst_strobe", {63'd0, frame_strobe}, 64'd0);

        // First strobe latency
        reset = 1'b0;
        cnt = 0;
        while (!frame_strobe && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_strobe_clks", 64'(cnt), 64'd4);

        // Stereo full-scale patterns
        capture("stereo", -1, 2'd0, 1'b0, lw, rw);
        chk("stereo_L", {48'd0, lw}, 64'h8001);
        chk("stereo_R", {48'd0, rw}, 64'h7FFE);

        // Frame period: capture ends 252 clocks after strobe
        cnt = 0;
        while (!frame_strobe && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        chk("frame_period", 64'(252 + cnt), 64'd256);

        // Mono saturation, positive, negative and cancelling
        mix_mode = 1'b1;
        snd1 = 16'h6000; snd2 = 16'h6000;
        @(negedge clk);
        capture("mono_pos", -1, 2'd0, 1'b0, lw, rw);
        chk("mono_pos_L", {48'd0, lw}, 64'h7FFF);
        chk("mono_pos_R", {48'd0, rw}, 64'h7FFF);
        snd1 = 16'hA000; snd2 = 16'hA000;
        capture("mono_neg", -1, 2'd0, 1'b0, lw, rw);
        chk("mono_neg_L", {48'd0, lw}, 64'h8000);
        chk("mono_neg_R", {48'd0, rw}, 64'h8000);
        snd1 = 16'h0100; snd2 = 16'hFF00;
        capture("mono_zero", -1, 2'd0, 1'b0, lw, rw);
        chk("mono_zero_L", {48'd0, lw}, 64'h0000);
        chk("mono_zero_R", {48'd0, rw}, 64'h0000);

        // Stereo with vol=2
        mix_mode = 1'b0;
        vol = 2'd2;
        snd1 = 16'hF000; snd2 = 16'h0010;
        capture("vol2", -1, 2'd0, 1'b0, lw, rw);
        chk("vol2_L", {48'd0, lw}, 64'hFC00);
        chk("vol2_R", {48'd0, rw}, 64'h0004);

        // vol changed mid-frame: this frame unchanged, next frame shifted by 3
        vol = 2'd0;
        snd1 = 16'h1234; snd2 = 16'h5678;
        capture("vol_pre", -1, 2'd0, 1'b0, lw, rw);
        capture("vol_mid", 10, 2'd3, 1'b0, lw, rw);
        chk("vol_mid_L", {48'd0, lw}, 64'h1234);
        chk("vol_mid_R", {48'd0, rw}, 64'h5678);
        capture("vol_next", -1, 2'd0, 1'b0, lw, rw);
        chk("vol_next_L", {48'd0, lw}, 64'h0246);
        chk("vol_next_R", {48'd0, rw}, 64'h0ACF);

        // mute asserted at bit 10
        vol = 2'd0;
        snd1 = 16'h4000; snd2 = 16'hC000;
        capture("mute_pre", -1, 2'd0, 1'b0, lw, rw);
        capture("mute_mid", 10, 2'd0, 1'b1, lw, rw);
        chk("mute_mid_L", {48'd0, lw}, 64'h4000);
        chk("mute_mid_R", {48'd0, rw}, 64'hC000);
        capture("mute_next", -1, 2'd0, 1'b1, lw, rw);
        chk("mute_next_L", {48'd0, lw}, 64'h0000);
        chk("mute_next_R", {48'd0, rw}, 64'h0000);

        // Reset pulsed at bit 20
        mute = 1'b0;
        cnt = 0;
        while (!frame_strobe && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        repeat (80) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_sclk", {63'd0, i2s_sclk}, 64'd0);
        chk("midrst_lrck", {63'd0, i2s_lrck}, 64'd0);
        chk("midrst_dat", {63'd0, i2s_dat}, 64'd0);
        snd1 = 16'hABCD; snd2 = 16'h0F0F;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (!frame_strobe && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_strobe_clks", 64'(cnt), 64'd4);
        capture("post_rst", -1, 2'd0, 1'b0, lw, rw);
        chk("post_rst_L", {48'd0, lw}, 64'hABCD);
        chk("post_rst_R", {48'd0, rw}, 64'h0F0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
